// File: rtl/exec_issue_unit_pkg.sv
// Shared ALU-issue definitions: operand/tag types, issue FSM states and the
// opcode numbers used by decode, the issue unit and the exec element.
package exec_pkg;

  typedef logic [5:0] inst_num_t;
  typedef logic [4:0] reg_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } issue_state_t;

  localparam inst_num_t OP_ADD  = 6'd8;
  localparam inst_num_t OP_ADDI = 6'd9;
  localparam inst_num_t OP_SUB  = 6'd10;
  localparam inst_num_t OP_DIV  = 6'd12;
  localparam inst_num_t OP_MULT = 6'd13;
  localparam inst_num_t OP_SLL  = 6'd16;

  localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/exec_issue_unit_if.sv
// Issue-unit bus: instruction intake, exec-element drive/return, writeback
// result and statistics. slave = issue unit view, master = surrounding pipeline.
interface exec_issue_unit_if;
  import exec_pkg::*;

  logic        in_valid;
  logic        in_ready;
  inst_num_t   in_inst_num;
  logic [31:0] in_const16_x;
  logic [4:0]  in_shift5;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  reg_tag_t    in_rd;

  logic        ee_reset;
  inst_num_t   ee_inst_num;
  logic [31:0] ee_const16_x;
  logic [4:0]  ee_shift5;
  logic [31:0] ee_rs;
  logic [31:0] ee_rt;
  logic        ee_completed;
  logic [31:0] ee_out;

  logic        out_valid;
  logic        out_ready;
  reg_tag_t    out_rd;
  logic [31:0] out_value;
  logic        out_err;

  logic [31:0] issued_count;
  logic [31:0] busy_cycles;

  modport slave (
    input  in_valid, in_inst_num, in_const16_x, in_shift5, in_rs, in_rt, in_rd,
    output in_ready,
    output ee_reset, ee_inst_num, ee_const16_x, ee_shift5, ee_rs, ee_rt,
    input  ee_completed, ee_out,
    output out_valid, out_rd, out_value, out_err,
    input  out_ready,
    output issued_count, busy_cycles
  );

  modport master (
    output in_valid, in_inst_num, in_const16_x, in_shift5, in_rs, in_rt, in_rd,
    input  in_ready,
    input  ee_reset, ee_inst_num, ee_const16_x, ee_shift5, ee_rs, ee_rt,
    output ee_completed, ee_out,
    input  out_valid, out_rd, out_value, out_err,
    output out_ready,
    input  issued_count, busy_cycles
  );

endinterface

// File: rtl/exec_issue_unit.sv
// Sequencer in front of the ALU exec element: latch, start, wait (with watchdog),
// present result. Define EXEC_ISSUE_STATS_EN to build the issue/busy counters.
module exec_issue_unit
  import exec_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  exec_issue_unit_if.slave bus
);

  issue_state_t       state_r;
  issue_state_t       state_next_s;
  logic               accept_s;
  logic               in_ready_s;
  logic               wdog_expired_s;
  logic [WDOG_W-1:0]  wdog_r;
  reg_tag_t           rd_r;
  inst_num_t          ee_inst_num_r;
  logic [31:0]        ee_const16_x_r;
  logic [4:0]         ee_shift5_r;
  logic [31:0]        ee_rs_r;
  logic [31:0]        ee_rt_r;
  logic [31:0]        out_value_r;
  reg_tag_t           out_rd_r;
  logic               out_err_r;
  logic               ee_reset_s;
  logic               out_valid_s;

  assign in_ready_s     = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
  assign accept_s       = bus.in_valid && in_ready_s;
  assign wdog_expired_s = (wdog_r == WDOG_W'(TIMEOUT_CYCLES - 32'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; completed is ignored in START because it may be stale
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = accept_s ? START : IDLE;
      START:   state_next_s = WAIT;
      WAIT:    state_next_s = (bus.ee_completed || wdog_expired_s) ? DONE : WAIT;
      DONE: begin
        if (accept_s) begin
          state_next_s = START;
        end else if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ee_reset_s  = reset || (state_r == START);
    out_valid_s = (state_r == DONE);
  end

  // Operand latch and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ee_inst_num_r  <= 6'd0;
      ee_const16_x_r <= 32'd0;
      ee_shift5_r    <= 5'd0;
      ee_rs_r        <= 32'd0;
      ee_rt_r        <= 32'd0;
      rd_r           <= 5'd0;
      out_value_r    <= 32'd0;
      out_rd_r       <= 5'd0;
      out_err_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        ee_inst_num_r  <= bus.in_inst_num;
        ee_const16_x_r <= bus.in_const16_x;
        ee_shift5_r    <= bus.in_shift5;
        ee_rs_r        <= bus.in_rs;
        ee_rt_r        <= bus.in_rt;
        rd_r           <= bus.in_rd;
      end
      if (state_r == WAIT) begin
        if (bus.ee_completed) begin
          out_value_r <= bus.ee_out;
          out_rd_r    <= rd_r;
          out_err_r   <= 1'b0;
        end else if (wdog_expired_s) begin
          out_value_r <= 32'd0;
          out_err_r   <= 1'b1;
        end
      end
    end
  end

  // Watchdog: restarted on every START, counts WAIT cycles without completion
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_r <= {WDOG_W{1'b0}};
    end else if (state_r == START) begin
      wdog_r <= {WDOG_W{1'b0}};
    end else if ((state_r == WAIT) && !bus.ee_completed && !wdog_expired_s) begin
      wdog_r <= wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef EXEC_ISSUE_STATS_EN
  logic [31:0] issued_count_r;
  logic [31:0] busy_cycles_r;

  // Statistics counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_count_r <= 32'd0;
      busy_cycles_r  <= 32'd0;
    end else begin
      if (accept_s) begin
        issued_count_r <= issued_count_r + 32'd1;
      end
      if (state_r != IDLE) begin
        busy_cycles_r <= busy_cycles_r + 32'd1;
      end
    end
  end

  assign bus.issued_count = issued_count_r;
  assign bus.busy_cycles  = busy_cycles_r;
`else
  assign bus.issued_count = 32'd0;
  assign bus.busy_cycles  = 32'd0;
`endif

  assign bus.in_ready     = in_ready_s;
  assign bus.ee_reset     = ee_reset_s;
  assign bus.ee_inst_num  = ee_inst_num_r;
  assign bus.ee_const16_x = ee_const16_x_r;
  assign bus.ee_shift5    = ee_shift5_r;
  assign bus.ee_rs        = ee_rs_r;
  assign bus.ee_rt        = ee_rt_r;
  assign bus.out_valid    = out_valid_s;
  assign bus.out_rd       = out_rd_r;
  assign bus.out_value    = out_value_r;
  assign bus.out_err      = out_err_r;

endmodule

// File: tb/tb_exec_issue_unit.sv
// Bench for exec_issue_unit with a behavioural exec-element model (variable
// latency / hang) and expectations computed from the issued instruction.
module tb_exec_issue_unit;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  exec_issue_unit_if ifc ();

  exec_issue_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;
  int model_lat  = 1;
  bit model_hang = 1'b0;
  int model_cnt  = 0;
  bit model_busy = 1'b0;

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] c,
                                          input logic [4:0] sh);
    case (op)
      OP_ADD:  return rs + rt;
      OP_ADDI: return rs + c;
      OP_SUB:  return rs - rt;
      OP_DIV:  return (rt == 32'd0) ? 32'hFFFF_FFFF : rs / rt;
      OP_MULT: return rs * rt;
      OP_SLL:  return rt << sh;
      default: return 32'd0;
    endcase
  endfunction

  // Exec element: cleared by ee_reset, finishes model_lat cycles later, flag registered
  always @(posedge clk) begin
    if (ifc.ee_reset) begin
      ifc.ee_completed <= 1'b0;
      model_busy       <= !model_hang;
      model_cnt        <= model_lat - 1;
    end else if (model_busy) begin
      if (model_cnt == 0) begin
        ifc.ee_completed <= 1'b1;
        ifc.ee_out       <= alu_ref(ifc.ee_inst_num, ifc.ee_rs, ifc.ee_rt,
                                    ifc.ee_const16_x, ifc.ee_shift5);
        model_busy       <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, follow it to DONE and check the result.
  // release_res=0 leaves the result pending in DONE with out_ready low.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] c, input logic [4:0] sh,
                        input logic [4:0] rd, input int lat, input bit hang,
                        input bit release_res);
    logic [31:0] exp_val;
    int          exp_lat;
    int          k;
    bit          seen;
    exp_val = hang ? 32'd0 : alu_ref(op, rs, rt, c, sh);
    exp_lat = hang ? 10 : 3 + lat;
    model_lat  = lat;
    model_hang = hang;
    ifc.out_ready    = 1'b1;
    ifc.in_valid     = 1'b1;
    ifc.in_inst_num  = op;
    ifc.in_rs        = rs;
    ifc.in_rt        = rt;
    ifc.in_const16_x = c;
    ifc.in_shift5    = sh;
    ifc.in_rd        = rd;
    seen = 1'b0;
    for (int w = 0; w < 40; w++) begin
      #1;
      if (ifc.in_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_accept"}, 32'(seen), 32'd1);
    if (!seen) begin
      ifc.in_valid = 1'b0;
      return;
    end
    check({tag, "_ee_reset_c0"}, 32'(ifc.ee_reset), 32'd0);
    @(posedge clk);
    accepts++;
    @(negedge clk);
    ifc.in_valid     = 1'b0;
    ifc.out_ready    = release_res;
    check({tag, "_ee_reset_c1"}, 32'(ifc.ee_reset), 32'd1);
    check({tag, "_out_valid_c1"}, 32'(ifc.out_valid), 32'd0);
    check({tag, "_in_ready_c1"}, 32'(ifc.in_ready), 32'd0);
    check({tag, "_ee_inst"}, 32'(ifc.ee_inst_num), 32'(op));
    check({tag, "_ee_rs"}, ifc.ee_rs, rs);
    check({tag, "_ee_rt"}, ifc.ee_rt, rt);
    check({tag, "_ee_const"}, ifc.ee_const16_x, c);
    check({tag, "_ee_shift"}, 32'(ifc.ee_shift5), 32'(sh));
    ifc.in_rs        = ~rs;
    ifc.in_const16_x = ~c;
    k = 1;
    seen = 1'b0;
    for (int n = 0; n < exp_lat + 20; n++) begin
      @(negedge clk);
      k++;
      if (ifc.out_valid) begin
        seen = 1'b1;
        break;
      end
      check({tag, "_ee_reset_wait"}, 32'(ifc.ee_reset), 32'd0);
    end
    check({tag, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, "_value"}, ifc.out_value, exp_val);
    check({tag, "_err"}, 32'(ifc.out_err), 32'(hang));
    if (!hang) check({tag, "_rd"}, 32'(ifc.out_rd), 32'(rd));
    check({tag, "_ee_rs_held"}, ifc.ee_rs, rs);
    check({tag, "_in_ready_done"}, 32'(ifc.in_ready), 32'(release_res));
`ifdef EXEC_ISSUE_STATS_EN
    check({tag, "_issued"}, ifc.issued_count, 32'(accepts));
`else
    check({tag, "_issued_tied"}, ifc.issued_count, 32'd0);
`endif
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{OP_ADD, OP_ADDI, OP_SUB, OP_DIV, OP_MULT, OP_SLL};
    reset = 1'b1;
    ifc.in_valid = 1'b0;  ifc.in_inst_num = 6'd0; ifc.in_rs = 32'd0; ifc.in_rt = 32'd0;
    ifc.in_const16_x = 32'd0; ifc.in_shift5 = 5'd0; ifc.in_rd = 5'd0; ifc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ee_reset", 32'(ifc.ee_reset), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ee_reset_low", 32'(ifc.ee_reset), 32'd0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_value", ifc.out_value, 32'd0);
    check("rst_out_rd", 32'(ifc.out_rd), 32'd0);
    check("rst_out_err", 32'(ifc.out_err), 32'd0);
    check("rst_ee_rs", ifc.ee_rs, 32'd0);
    check("rst_ee_inst", 32'(ifc.ee_inst_num), 32'd0);
    check("rst_busy", ifc.busy_cycles, 32'd0);

    run_op("add", OP_ADD, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 1, 1'b0, 1'b1);

    run_op("bp", OP_ADDI, 32'd1, 32'd99, 32'h10, 5'd0, 5'd6, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(ifc.out_valid), 32'd1);
      check("bp_value_hold", ifc.out_value, 32'h11);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    end
    ifc.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(ifc.in_ready), 32'd1);
    @(negedge clk);
    check("bp_released", 32'(ifc.out_valid), 32'd0);

    run_op("b2b_first", OP_MULT, 32'd6, 32'd7, 32'd0, 5'd0, 5'd1, 1, 1'b0, 1'b0);
    ifc.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(ifc.in_ready), 32'd1);
    check("stale_completed_high", 32'(ifc.ee_completed), 32'd1);
    run_op("b2b_sub", OP_SUB, 32'd9, 32'd4, 32'd0, 5'd0, 5'd2, 1, 1'b0, 1'b1);

    run_op("timeout", OP_DIV, 32'd100, 32'd3, 32'd0, 5'd0, 5'd4, 1, 1'b1, 1'b1);

    ifc.out_ready = 1'b1;
    model_lat = 30;
    model_hang = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_inst_num = OP_DIV; ifc.in_rs = 32'd100; ifc.in_rt = 32'd7;
    ifc.in_rd = 5'd9;
    #1;
    check("mid_rst_accept_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ee_reset", 32'(ifc.ee_reset), 32'd1);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_idle", 32'(ifc.in_ready), 32'd1);
    check("mid_rst_ee_rs", ifc.ee_rs, 32'd0);
    check("mid_rst_ee_reset_hold", 32'(ifc.ee_reset), 32'd1);
    reset = 1'b0;
    accepts = 0;
    run_op("post_rst_add", OP_ADD, 32'd2, 32'd2, 32'd0, 5'd0, 5'd5, 1, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      run_op("rand", ops[$urandom_range(0, 5)], $urandom, $urandom_range(0, 40), $urandom,
             5'($urandom), 5'($urandom), $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)));
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("drain_out_valid", 32'(ifc.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
